// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard unit: write-back source
// bit positions, forwarding select codes and the freeze-tracking state.
package hazard_pkg;

    // Bit positions inside the one-hot WBSrc vectors.
    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int WB_MULT = 2;
    localparam int WB_PC8  = 3;

    // E-stage operand select codes.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Why the pipeline is (or is not) frozen.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MISS = 2'd1,
        ST_MULT = 2'd2
    } hz_state_e;

    // E-stage forward select for one source register. The M stage holds the
    // younger result, so it wins over W. Register 0 is never forwarded.
    function automatic logic [1:0] e_fwd_sel(
        input logic [4:0] src,
        input logic       wr_m,
        input logic [4:0] dst_m,
        input logic       wr_w,
        input logic [4:0] dst_w
    );
        if (src != 5'd0 && wr_m && src == dst_m) begin
            return FWD_M;
        end
        if (src != 5'd0 && wr_w && src == dst_w) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/freeze_watchdog.sv
// Counts consecutive frozen cycles and raises a sticky error flag once the
// count reaches TIMEOUT. It only observes; it never releases the freeze.
module freeze_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic frozen,
    output logic hazard_err
);

    localparam int                 CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Saturating frozen-cycle count; the flag latches when the count hits LIMIT.
    always_comb begin
        cnt_d = '0;
        if (frozen) begin
            cnt_d = (cnt_q == LIMIT) ? LIMIT : cnt_q + CNT_W'(1);
        end
        err_d = err_q | (cnt_d == LIMIT);
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign hazard_err = err_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline control for the five-stage core: forwarding selects, load-use and
// branch stalls, and a whole-pipeline freeze while a data-cache miss or a
// multiplier result is outstanding. Control only, no datapath values.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] branchD,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic       RegWriteE,
    input  logic       MultStartE,
    input  logic       MultDoneE,
    input  logic [3:0] WBSrcE,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic       RegWriteM,
    input  logic       hitM,
    input  logic [3:0] WBSrcM,
    input  logic [4:0] WriteRegM,
    input  logic       RegWriteW,
    input  logic [4:0] WriteRegW,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       stallW,
    output logic       flushE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       hazard_err
);

    logic [4:0] src_e [2];
    logic [4:0] src_d [2];
    logic [1:0] fwd_e [2];
    logic [1:0] fwd_d;
    logic [1:0] use_match;
    logic [1:0] br_e_match;
    logic [1:0] br_m_match;

    logic       busy_q, busy_d;
    hz_state_e  state_q, state_d;

    logic       miss_m, mult_wait, frozen;
    logic       use_stall, branch_stall, d_stall;
    logic       m_late_result;

    // The ALU bits (and MULT in M) carry no hazard information.
    logic unused_wbsrc;
    assign unused_wbsrc = ^{WBSrcE[WB_ALU], WBSrcM[WB_ALU], WBSrcM[WB_MULT]};

    assign src_e[0] = RsE;
    assign src_e[1] = RtE;
    assign src_d[0] = RsD;
    assign src_d[1] = RtD;

    // Results that are not yet in ALUMultOutM while in M (load data, link PC).
    assign m_late_result = WBSrcM[WB_LOAD] | WBSrcM[WB_PC8];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            assign fwd_e[gi]      = e_fwd_sel(src_e[gi], RegWriteM, WriteRegM,
                                              RegWriteW, WriteRegW);
            assign fwd_d[gi]      = (src_d[gi] != 5'd0) && RegWriteM &&
                                    (src_d[gi] == WriteRegM) && !m_late_result;
            assign use_match[gi]  = (RtE == src_d[gi]);
            assign br_e_match[gi] = (WriteRegE == src_d[gi]);
            assign br_m_match[gi] = (WriteRegM == src_d[gi]);
        end
    endgenerate

    assign miss_m    = WBSrcM[WB_LOAD] && !hitM;
    assign mult_wait = busy_q && !MultDoneE && (WBSrcE[WB_MULT] || MultStartE);
    assign frozen    = miss_m | mult_wait;

    assign use_stall = (WBSrcE[WB_LOAD] | WBSrcE[WB_PC8]) && (RtE != 5'd0) &&
                       (|use_match);

    assign branch_stall = (branchD != 2'd0) &&
                          ((RegWriteE && (WriteRegE != 5'd0) && (|br_e_match)) ||
                           (RegWriteM && m_late_result && (|br_m_match)));

    assign d_stall = use_stall | branch_stall;

    // Stall, flush and forward outputs; reset forces the pipeline to run clean.
    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        stallW    = 1'b0;
        flushE    = 1'b0;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        if (!rst) begin
            stallF    = frozen | d_stall;
            stallD    = frozen | d_stall;
            stallE    = frozen;
            stallM    = frozen;
            stallW    = frozen;
            flushE    = !frozen && d_stall;
            forwardAD = fwd_d[0];
            forwardBD = fwd_d[1];
            forwardAE = fwd_e[0];
            forwardBE = fwd_e[1];
        end
    end

    // Multiplier occupancy and freeze-cause tracking, next-state.
    always_comb begin
        busy_d = busy_q | (MultStartE && !frozen);
        if (MultDoneE) begin
            busy_d = MultStartE && !frozen;
        end

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (miss_m)         state_d = ST_MISS;
                else if (mult_wait) state_d = ST_MULT;
            end
            ST_MISS: begin
                if (!miss_m)        state_d = mult_wait ? ST_MULT : ST_RUN;
            end
            ST_MULT: begin
                if (miss_m)         state_d = ST_MISS;
                else if (!mult_wait) state_d = ST_RUN;
            end
            default:                state_d = ST_RUN;
        endcase
    end

    // Occupancy and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            busy_q  <= busy_d;
            state_q <= state_d;
        end
    end

    logic freeze_tracked;
    assign freeze_tracked = (state_d != ST_RUN);

    freeze_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .frozen     (freeze_tracked),
        .hazard_err (hazard_err)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a table of single-cycle vectors for the
// combinational forwarding/stall logic, then hand-written multi-cycle
// sequences for miss, multiply, watchdog and reset behaviour.
module tb_hazard_unit;

    localparam logic [3:0] W_ALU = 4'b0001;
    localparam logic [3:0] W_LD  = 4'b0010;
    localparam logic [3:0] W_MUL = 4'b0100;
    localparam logic [3:0] W_PC8 = 4'b1000;

    // {stallF,stallD,stallE,stallM,stallW,flushE,fAD,fBD,fAE,fBE}
    localparam logic [11:0] O_NONE   = 12'b00000_0_0_0_00_00;
    localparam logic [11:0] O_FROZEN = 12'b11111_0_0_0_00_00;
    localparam logic [11:0] O_USE    = 12'b11000_1_0_0_00_00;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] branchD;
    logic [4:0] RsD, RtD;
    logic       RegWriteE, MultStartE, MultDoneE;
    logic [3:0] WBSrcE;
    logic [4:0] RsE, RtE, WriteRegE;
    logic       RegWriteM, hitM;
    logic [3:0] WBSrcM;
    logic [4:0] WriteRegM;
    logic       RegWriteW;
    logic [4:0] WriteRegW;
    logic       stallF, stallD, stallE, stallM, stallW, flushE;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       hazard_err;

    always #5 clk = ~clk;

    hazard_unit #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .branchD(branchD), .RsD(RsD), .RtD(RtD),
        .RegWriteE(RegWriteE), .MultStartE(MultStartE), .MultDoneE(MultDoneE),
        .WBSrcE(WBSrcE), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
        .RegWriteM(RegWriteM), .hitM(hitM), .WBSrcM(WBSrcM), .WriteRegM(WriteRegM),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .stallW(stallW), .flushE(flushE), .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .hazard_err(hazard_err)
    );

    logic [11:0] obs;
    assign obs = {stallF, stallD, stallE, stallM, stallW, flushE,
                  forwardAD, forwardBD, forwardAE, forwardBE};

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] branchD;
        logic [4:0] RsD, RtD;
        logic       RegWriteE;
        logic [3:0] WBSrcE;
        logic [4:0] RsE, RtE, WriteRegE;
        logic       RegWriteM, hitM;
        logic [3:0] WBSrcM;
        logic [4:0] WriteRegM;
        logic       RegWriteW;
        logic [4:0] WriteRegW;
        logic [4:0] e_stall;
        logic       e_flush, e_fad, e_fbd;
        logic [1:0] e_fae, e_fbe;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vec [NVEC];

    task automatic idle();
        branchD = 2'd0; RsD = 5'd0; RtD = 5'd0;
        RegWriteE = 1'b0; MultStartE = 1'b0; MultDoneE = 1'b0; WBSrcE = 4'd0;
        RsE = 5'd0; RtE = 5'd0; WriteRegE = 5'd0;
        RegWriteM = 1'b0; hitM = 1'b1; WBSrcM = 4'd0; WriteRegM = 5'd0;
        RegWriteW = 1'b0; WriteRegW = 5'd0;
    endtask

    task automatic apply(input vec_t v);
        branchD = v.branchD; RsD = v.RsD; RtD = v.RtD;
        RegWriteE = v.RegWriteE; WBSrcE = v.WBSrcE;
        RsE = v.RsE; RtE = v.RtE; WriteRegE = v.WriteRegE;
        RegWriteM = v.RegWriteM; hitM = v.hitM; WBSrcM = v.WBSrcM; WriteRegM = v.WriteRegM;
        RegWriteW = v.RegWriteW; WriteRegW = v.WriteRegW;
        MultStartE = 1'b0; MultDoneE = 1'b0;
    endtask

    // Load in M that misses the data cache.
    task automatic set_miss();
        idle();
        RegWriteM = 1'b1; WBSrcM = W_LD; WriteRegM = 5'd2; hitM = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_obs(input string nm, input logic [11:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b", nm, obs, exp);
        end else begin
            $display("check %s outputs=%b", nm, obs);
        end
    endtask

    task automatic check_err(input string nm, input logic exp);
        checks++;
        if (hazard_err !== exp) begin
            failures++;
            $display("FAIL %s hazard_err got=%b want=%b", nm, hazard_err, exp);
        end else begin
            $display("check %s hazard_err=%b", nm, hazard_err);
        end
    endtask

    initial begin
        // brD RsD RtD  RWE WBE  RsE RtE WRE  RWM hit WBM WRM  RWW WRW  stall flush fAD fBD fAE fBE
        vec[0]  = '{2'd0, 5'd0,  5'd0,  1'b0, W_ALU, 5'd3, 5'd0,  5'd0,  1'b1, 1'b1, W_ALU, 5'd3,  1'b1, 5'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
        vec[1]  = '{2'd0, 5'd0,  5'd0,  1'b0, W_ALU, 5'd3, 5'd0,  5'd0,  1'b0, 1'b1, W_ALU, 5'd3,  1'b1, 5'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
        vec[2]  = '{2'd0, 5'd0,  5'd0,  1'b0, W_ALU, 5'd0, 5'd0,  5'd0,  1'b1, 1'b1, W_ALU, 5'd0,  1'b1, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[3]  = '{2'd0, 5'd0,  5'd0,  1'b0, W_ALU, 5'd8, 5'd7,  5'd0,  1'b1, 1'b1, W_ALU, 5'd8,  1'b1, 5'd7, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01};
        vec[4]  = '{2'd0, 5'd9,  5'd10, 1'b0, 4'd0,  5'd0, 5'd0,  5'd0,  1'b1, 1'b1, W_ALU, 5'd10, 1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00};
        vec[5]  = '{2'd0, 5'd10, 5'd0,  1'b0, 4'd0,  5'd0, 5'd0,  5'd0,  1'b1, 1'b1, W_LD,  5'd10, 1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[6]  = '{2'd0, 5'd5,  5'd0,  1'b1, W_LD,  5'd0, 5'd5,  5'd5,  1'b0, 1'b1, 4'd0,  5'd0,  1'b0, 5'd0, 5'b11000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[7]  = '{2'd0, 5'd0,  5'd31, 1'b1, W_PC8, 5'd0, 5'd31, 5'd31, 1'b0, 1'b1, 4'd0,  5'd0,  1'b0, 5'd0, 5'b11000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[8]  = '{2'd0, 5'd0,  5'd0,  1'b1, W_LD,  5'd0, 5'd0,  5'd0,  1'b0, 1'b1, 4'd0,  5'd0,  1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[9]  = '{2'd1, 5'd4,  5'd0,  1'b1, W_ALU, 5'd0, 5'd0,  5'd4,  1'b0, 1'b1, 4'd0,  5'd0,  1'b0, 5'd0, 5'b11000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[10] = '{2'd1, 5'd4,  5'd0,  1'b0, 4'd0,  5'd0, 5'd0,  5'd0,  1'b1, 1'b1, W_ALU, 5'd4,  1'b0, 5'd0, 5'b00000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
        vec[11] = '{2'd2, 5'd0,  5'd6,  1'b0, 4'd0,  5'd0, 5'd0,  5'd0,  1'b1, 1'b1, W_LD,  5'd6,  1'b0, 5'd0, 5'b11000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[12] = '{2'd0, 5'd4,  5'd0,  1'b1, W_ALU, 5'd0, 5'd0,  5'd4,  1'b0, 1'b1, 4'd0,  5'd0,  1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[13] = '{2'd0, 5'd5,  5'd0,  1'b1, W_LD,  5'd0, 5'd5,  5'd5,  1'b1, 1'b0, W_LD,  5'd2,  1'b0, 5'd0, 5'b11111, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[14] = '{2'd3, 5'd0,  5'd0,  1'b1, W_ALU, 5'd0, 5'd0,  5'd0,  1'b0, 1'b1, 4'd0,  5'd0,  1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[15] = '{2'd1, 5'd31, 5'd0,  1'b0, 4'd0,  5'd0, 5'd0,  5'd0,  1'b1, 1'b1, W_PC8, 5'd31, 1'b0, 5'd0, 5'b11000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};

        // Reset: outputs forced quiet regardless of inputs.
        rst = 1'b1;
        idle();
        next_cycle(); apply(vec[13]); sample(); check_obs("reset_freeze_gated", O_NONE);
        next_cycle(); apply(vec[3]);  sample(); check_obs("reset_fwd_gated", O_NONE);
        next_cycle(); rst = 1'b0; idle(); sample();
        check_obs("reset_idle", O_NONE);
        check_err("reset_err", 1'b0);

        // Single-cycle vector table.
        for (int i = 0; i < NVEC; i++) begin
            next_cycle();
            apply(vec[i]);
            sample();
            check_obs($sformatf("vec%0d", i),
                      {vec[i].e_stall, vec[i].e_flush, vec[i].e_fad, vec[i].e_fbd,
                       vec[i].e_fae, vec[i].e_fbe});
        end

        // Load-use stall lasts one cycle: the load moves on, bubble follows.
        next_cycle(); apply(vec[6]); sample(); check_obs("use_stall", O_USE);
        next_cycle(); idle();        sample(); check_obs("use_release", O_NONE);

        // Data-cache miss held for five cycles, released when hitM rises.
        for (int i = 0; i < 5; i++) begin
            next_cycle(); set_miss(); sample();
            check_obs($sformatf("miss_cyc%0d", i), O_FROZEN);
        end
        next_cycle(); set_miss(); hitM = 1'b1; sample();
        check_obs("miss_release", O_NONE);
        check_err("miss_no_err", 1'b0);

        // Multiply: start, then mflo waits three cycles, release on done.
        next_cycle(); idle(); MultStartE = 1'b1; sample(); check_obs("mult_start", O_NONE);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); idle(); WBSrcE = W_MUL; sample();
            check_obs($sformatf("mult_wait%0d", i), O_FROZEN);
        end
        next_cycle(); idle(); WBSrcE = W_MUL; MultDoneE = 1'b1; sample();
        check_obs("mult_done", O_NONE);
        next_cycle(); idle(); WBSrcE = W_MUL; sample(); check_obs("mult_busy_cleared", O_NONE);

        // Start and done together leave the multiplier busy.
        next_cycle(); idle(); MultStartE = 1'b1; MultDoneE = 1'b1; sample();
        check_obs("mult_coincident", O_NONE);
        next_cycle(); idle(); WBSrcE = W_MUL; sample(); check_obs("mult_still_busy", O_FROZEN);
        next_cycle(); idle(); WBSrcE = W_MUL; MultDoneE = 1'b1; sample();
        check_obs("mult_done2", O_NONE);

        // Reset mid-multiply forgets busy.
        next_cycle(); idle(); MultStartE = 1'b1; sample(); check_obs("mult_start_rst", O_NONE);
        next_cycle(); idle(); WBSrcE = W_MUL; rst = 1'b1; sample();
        check_obs("mult_rst_gated", O_NONE);
        next_cycle(); idle(); WBSrcE = W_MUL; rst = 1'b0; sample();
        check_obs("mult_rst_forgot", O_NONE);

        // Watchdog: flag sets with the 64th frozen cycle and stays set.
        for (int k = 1; k <= 64; k++) begin
            next_cycle(); set_miss(); sample();
            check_err($sformatf("wd_frozen%0d", k), 1'b0);
        end
        next_cycle(); set_miss(); sample();
        check_obs("wd_still_frozen", O_FROZEN);
        check_err("wd_err_set", 1'b1);
        next_cycle(); set_miss(); hitM = 1'b1; sample();
        check_obs("wd_release", O_NONE);
        check_err("wd_err_sticky", 1'b1);

        // Reset mid-freeze releases everything on the next cycle.
        next_cycle(); set_miss(); sample(); check_obs("refreeze", O_FROZEN);
        next_cycle(); set_miss(); rst = 1'b1; sample(); check_obs("rst_midfreeze", O_NONE);
        next_cycle(); idle(); rst = 1'b0; sample();
        check_obs("post_rst_outputs", O_NONE);
        check_err("post_rst_err", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
